// File: rtl/merge_ctrl.sv
// Two-way merge controller: pops the smaller head of FIFO A/B into the output FIFO (ties take A).
// Zero-latency combinational write path; stalls without popping while out_full or a needed FIFO is empty.
module merge_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  run_len,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_empty,
  output logic                  a_rd_en,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_empty,
  output logic                  b_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MERGE,
    S_DRAIN_A,
    S_DRAIN_B,
    S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_a_q, rem_a_d;
  logic [LEN_WIDTH-1:0] rem_b_q, rem_b_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rem_a_q <= '0;
      rem_b_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_a_q <= rem_a_d;
      rem_b_q <= rem_b_d;
      done_q  <= done_d;
    end
  end

  // Counters only decrement on an actual pop, and pops are gated on a non-zero count.
  always_comb begin
    state_d = state_q;
    rem_a_d = a_rd_en ? rem_a_q - LEN_WIDTH'(1) : rem_a_q;
    rem_b_d = b_rd_en ? rem_b_q - LEN_WIDTH'(1) : rem_b_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_a_d = run_len;
          rem_b_d = run_len;
          state_d = (run_len != '0) ? S_MERGE : S_FINISH;
        end
      end
      S_MERGE: begin
        if (rem_a_d == '0) begin
          state_d = S_DRAIN_B;
        end else if (rem_b_d == '0) begin
          state_d = S_DRAIN_A;
        end
      end
      S_DRAIN_A: begin
        if (rem_a_d == '0) state_d = S_FINISH;
      end
      S_DRAIN_B: begin
        if (rem_b_d == '0) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // done is high exactly while the FSM sits in FINISH
    done_d = (state_d == S_FINISH);
  end

  always_comb begin
    a_rd_en = 1'b0;
    b_rd_en = 1'b0;
    case (state_q)
      S_MERGE: begin
        if (!out_full && !a_empty && !b_empty && (rem_a_q != '0) && (rem_b_q != '0)) begin
          if (a_data <= b_data) a_rd_en = 1'b1;
          else                  b_rd_en = 1'b1;
        end
      end
      S_DRAIN_A: a_rd_en = !out_full && !a_empty && (rem_a_q != '0);
      S_DRAIN_B: b_rd_en = !out_full && !b_empty && (rem_b_q != '0);
      default: ;
    endcase
    out_wr_en = a_rd_en | b_rd_en;
    out_data  = a_rd_en ? a_data : (b_rd_en ? b_data : '0);
    busy      = (state_q != S_IDLE);
    done      = done_q;
  end

endmodule
